// File: rtl/ip_rx_protocol_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ip_rx_protocol_dispatch_pkg
// Purpose  : Shared IPv4 constants, route/state types and small helpers for
//            the IPv4 RX protocol dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
package ip_rx_protocol_dispatch_pkg;

  localparam logic [7:0] IPV4_PROTO_ICMP = 8'h01;
  localparam logic [7:0] IPV4_PROTO_TCP  = 8'h06;
  localparam logic [7:0] IPV4_PROTO_UDP  = 8'h11;
  localparam int         IPV4_HDR_BYTES  = 20;

  typedef enum logic [1:0] {
    ROUTE_ICMP = 2'd0,
    ROUTE_TCP  = 2'd1,
    ROUTE_UDP  = 2'd2
  } route_t;

  typedef enum logic [1:0] {
    ST_HDR   = 2'd0,
    ST_FWD   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DROP  = 2'd3
  } dispatch_state_t;

  // Number of beats needed to hold the fixed 20-byte IPv4 header.
  function automatic int dec_beats(input int width);
    return (IPV4_HDR_BYTES * 8 + width - 1) / width;
  endfunction

  function automatic logic proto_supported(input logic [7:0] proto);
    return (proto == IPV4_PROTO_ICMP) || (proto == IPV4_PROTO_TCP) ||
           (proto == IPV4_PROTO_UDP);
  endfunction

  function automatic route_t proto_route(input logic [7:0] proto);
    case (proto)
      IPV4_PROTO_ICMP: return ROUTE_ICMP;
      IPV4_PROTO_TCP:  return ROUTE_TCP;
      default:         return ROUTE_UDP;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ip_rx_protocol_dispatch_hdr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ip_rx_hdr_fifo
// Purpose  : Small shift-register FIFO with flush. Entry 0 is always the head,
//            so the head is a plain register and the whole contents can be
//            peeked in arrival order (used for header parsing).
// Revision : 1.0 - initial release
// ============================================================================
module ip_rx_hdr_fifo
  import ip_rx_protocol_dispatch_pkg::*;
#(
  parameter int  DEPTH = 3,
  parameter int  DW    = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                push,
  input  logic [DW-1:0]       push_data,
  input  logic                pop,
  output logic [DW-1:0]       head,
  output logic [DEPTH*DW-1:0] peek,
  output logic                empty,
  output logic                full,
  output logic [CNT_W-1:0]    count
);

  logic [DW-1:0]    mem     [DEPTH];
  logic [DW-1:0]    mem_nxt [DEPTH];
  logic [CNT_W-1:0] wr_idx;

  // Next storage contents: shift down on pop, write new entry behind the tail.
  always_comb begin
    wr_idx = pop ? (count - CNT_W'(1)) : count;
    for (int i = 0; i < DEPTH; i++) begin
      mem_nxt[i] = pop ? mem[(i < DEPTH - 1) ? i + 1 : i] : mem[i];
      if (push && (wr_idx == CNT_W'(i))) begin
        mem_nxt[i] = push_data;
      end
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] <= mem_nxt[i];
    end
  end

  // Occupancy counter; flush empties the FIFO in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Head, peek and status flags come straight from registers.
  always_comb begin
    head  = mem[0];
    empty = (count == '0);
    full  = (count == CNT_W'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      peek[i*DW +: DW] = mem[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/ip_rx_protocol_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : ip_rx_protocol_dispatch
// Purpose  : Parses the IPv4 header of each incoming packet and steers the
//            whole packet to the UDP, TCP or ICMP output stream, dropping
//            malformed, foreign or unsupported packets. Header beats are
//            buffered until the routing decision is made.
// Options  : IP_RX_DISPATCH_STATS_EN adds saturating drop/runt counters.
// Revision : 1.0 - initial release
// ============================================================================
module ip_rx_protocol_dispatch
  import ip_rx_protocol_dispatch_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic               net_clk,
  input  logic               net_aresetn,
  input  logic [31:0]        local_ip_address,

  input  logic [WIDTH-1:0]   s_axis_rx_data_tdata,
  input  logic [WIDTH/8-1:0] s_axis_rx_data_tkeep,
  input  logic               s_axis_rx_data_tlast,
  input  logic               s_axis_rx_data_tvalid,
  output logic               s_axis_rx_data_tready,

  output logic [WIDTH-1:0]   m_axis_udp_data_tdata,
  output logic [WIDTH/8-1:0] m_axis_udp_data_tkeep,
  output logic               m_axis_udp_data_tlast,
  output logic               m_axis_udp_data_tvalid,
  input  logic               m_axis_udp_data_tready,

  output logic [WIDTH-1:0]   m_axis_tcp_data_tdata,
  output logic [WIDTH/8-1:0] m_axis_tcp_data_tkeep,
  output logic               m_axis_tcp_data_tlast,
  output logic               m_axis_tcp_data_tvalid,
  input  logic               m_axis_tcp_data_tready,

  output logic [WIDTH-1:0]   m_axis_icmp_data_tdata,
  output logic [WIDTH/8-1:0] m_axis_icmp_data_tkeep,
  output logic               m_axis_icmp_data_tlast,
  output logic               m_axis_icmp_data_tvalid,
`ifdef IP_RX_DISPATCH_STATS_EN
  output logic [31:0]        drop_count,
  output logic [15:0]        runt_count,
`endif
  input  logic               m_axis_icmp_data_tready
);

  localparam int         KEEP_W       = WIDTH / 8;
  localparam int         DEC_BEATS    = dec_beats(WIDTH);
  localparam int         ENT_W        = WIDTH + KEEP_W + 1;
  localparam int         HDR_W        = DEC_BEATS * WIDTH;
  localparam int         CNT_W        = $clog2(DEC_BEATS + 1);
  localparam logic [1:0] LAST_HDR_IDX = 2'(DEC_BEATS - 1);

  dispatch_state_t state;
  route_t          route;
  logic            route_en;
  logic            alive;
  logic [1:0]      hdr_idx;

  logic [ENT_W-1:0]           fifo_head;
  logic [DEC_BEATS*ENT_W-1:0] fifo_peek;
  logic                       fifo_empty;
  logic                       fifo_full;
  logic [CNT_W-1:0]           fifo_count;
  logic                       push;
  logic                       pop;
  logic                       flush;

  logic             accept;
  logic             is_dec;
  logic             is_runt;
  logic             hdr_ok;
  logic [HDR_W-1:0] hdr_vec;
  logic [3:0]       hdr_version;
  logic [7:0]       hdr_proto;
  logic [31:0]      hdr_dst;
  logic             sel_ready;
  logic             unused_bits;

  // Header view: buffered beats in arrival order plus the decision beat.
  always_comb begin
    hdr_vec = '0;
    for (int k = 0; k < DEC_BEATS; k++) begin
      if (k == DEC_BEATS - 1) begin
        hdr_vec[k*WIDTH +: WIDTH] = s_axis_rx_data_tdata;
      end else begin
        hdr_vec[k*WIDTH +: WIDTH] = fifo_peek[k*ENT_W +: WIDTH];
      end
    end
    hdr_version = hdr_vec[7:4];
    hdr_proto   = hdr_vec[79:72];
    hdr_dst     = hdr_vec[159:128];
    hdr_ok      = (hdr_version == 4'd4) &&
                  ((hdr_dst == local_ip_address) || (hdr_dst == 32'hFFFF_FFFF)) &&
                  proto_supported(hdr_proto);
  end

  assign unused_bits = ^{fifo_peek, hdr_vec};

  // Handshake, FIFO control and input ready per state.
  always_comb begin
    case (route)
      ROUTE_ICMP: sel_ready = m_axis_icmp_data_tready;
      ROUTE_TCP:  sel_ready = m_axis_tcp_data_tready;
      default:    sel_ready = m_axis_udp_data_tready;
    endcase
    pop = !fifo_empty && route_en && sel_ready;

    case (state)
      ST_HDR:   s_axis_rx_data_tready = alive && !fifo_full;
      ST_FWD:   s_axis_rx_data_tready = !fifo_full || pop;
      ST_DRAIN: s_axis_rx_data_tready = 1'b0;
      default:  s_axis_rx_data_tready = 1'b1;
    endcase

    accept  = s_axis_rx_data_tvalid && s_axis_rx_data_tready;
    is_dec  = (state == ST_HDR) && accept && (hdr_idx == LAST_HDR_IDX);
    is_runt = (state == ST_HDR) && accept && s_axis_rx_data_tlast &&
              (hdr_idx != LAST_HDR_IDX);
    flush   = is_runt || (is_dec && !hdr_ok);
    push    = accept && !flush && ((state == ST_HDR) || (state == ST_FWD));
  end

  ip_rx_hdr_fifo #(
    .DEPTH (DEC_BEATS),
    .DW    (ENT_W)
  ) u_hdr_fifo (
    .clk       (net_clk),
    .rst_n     (net_aresetn),
    .flush     (flush),
    .push      (push),
    .push_data ({s_axis_rx_data_tlast, s_axis_rx_data_tkeep, s_axis_rx_data_tdata}),
    .pop       (pop),
    .head      (fifo_head),
    .peek      (fifo_peek),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // Dispatch FSM: header collection, forwarding, draining and dropping.
  always_ff @(posedge net_clk or negedge net_aresetn) begin
    if (!net_aresetn) begin
      state    <= ST_HDR;
      route    <= ROUTE_UDP;
      route_en <= 1'b0;
      alive    <= 1'b0;
      hdr_idx  <= '0;
    end else begin
      alive <= 1'b1;
      case (state)
        ST_HDR: begin
          if (is_runt) begin
            hdr_idx <= '0;
          end else if (is_dec) begin
            hdr_idx <= '0;
            if (hdr_ok) begin
              route    <= proto_route(hdr_proto);
              route_en <= 1'b1;
              state    <= s_axis_rx_data_tlast ? ST_DRAIN : ST_FWD;
            end else begin
              state <= s_axis_rx_data_tlast ? ST_HDR : ST_DROP;
            end
          end else if (accept) begin
            hdr_idx <= hdr_idx + 2'd1;
          end
        end
        ST_FWD: begin
          if (accept && s_axis_rx_data_tlast) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty || (pop && (fifo_count == CNT_W'(1)))) begin
            route_en <= 1'b0;
            state    <= ST_HDR;
          end
        end
        default: begin
          if (accept && s_axis_rx_data_tlast) begin
            state <= ST_HDR;
          end
        end
      endcase
    end
  end

  // All outputs share the FIFO head; only the routed one is valid.
  always_comb begin
    m_axis_udp_data_tdata   = fifo_head[WIDTH-1:0];
    m_axis_udp_data_tkeep   = fifo_head[WIDTH +: KEEP_W];
    m_axis_udp_data_tlast   = fifo_head[ENT_W-1];
    m_axis_tcp_data_tdata   = fifo_head[WIDTH-1:0];
    m_axis_tcp_data_tkeep   = fifo_head[WIDTH +: KEEP_W];
    m_axis_tcp_data_tlast   = fifo_head[ENT_W-1];
    m_axis_icmp_data_tdata  = fifo_head[WIDTH-1:0];
    m_axis_icmp_data_tkeep  = fifo_head[WIDTH +: KEEP_W];
    m_axis_icmp_data_tlast  = fifo_head[ENT_W-1];
    m_axis_udp_data_tvalid  = !fifo_empty && route_en && (route == ROUTE_UDP);
    m_axis_tcp_data_tvalid  = !fifo_empty && route_en && (route == ROUTE_TCP);
    m_axis_icmp_data_tvalid = !fifo_empty && route_en && (route == ROUTE_ICMP);
  end

`ifdef IP_RX_DISPATCH_STATS_EN
  // Saturating counters of dropped packets and of runts among them.
  always_ff @(posedge net_clk or negedge net_aresetn) begin
    if (!net_aresetn) begin
      drop_count <= '0;
      runt_count <= '0;
    end else begin
      if (flush && (drop_count != 32'hFFFF_FFFF)) begin
        drop_count <= drop_count + 32'd1;
      end
      if (is_runt && (runt_count != 16'hFFFF)) begin
        runt_count <= runt_count + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ip_rx_protocol_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ip_rx_protocol_dispatch
// Purpose  : Scoreboard bench for ip_rx_protocol_dispatch at WIDTH=64 with
//            local address 10.0.0.1. Stimulus pushes expected beats (tagged
//            with their output port) into one ordered queue; a monitor pops
//            and compares on every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ip_rx_protocol_dispatch;

  localparam int          WIDTH    = 64;
  localparam int          KW       = WIDTH / 8;
  localparam int          DEC      = 3;
  localparam logic [31:0] LOCAL_IP = 32'h0100_000A; // 10.0.0.1, byte 0 in [7:0]
  localparam logic [31:0] OTHER_IP = 32'h0200_000A; // 10.0.0.2
  localparam logic [31:0] BCAST_IP = 32'hFFFF_FFFF;

  logic             clk;
  logic             net_aresetn;
  logic [WIDTH-1:0] s_data;
  logic [KW-1:0]    s_keep;
  logic             s_last;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] m_data [3];
  logic [KW-1:0]    m_keep [3];
  logic [2:0]       m_last;
  logic [2:0]       m_valid;
  logic [2:0]       m_ready;
`ifdef IP_RX_DISPATCH_STATS_EN
  logic [31:0]      drop_count;
  logic [15:0]      runt_count;
`endif

  typedef struct {
    int               port;
    logic [WIDTH-1:0] data;
    logic [KW-1:0]    keep;
    logic             last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   rcv[3] = '{0, 0, 0};
  int   rdy_mode = 0;

  // Port index: 0 = UDP, 1 = TCP, 2 = ICMP
  ip_rx_protocol_dispatch #(.WIDTH(WIDTH)) dut (
    .net_clk                 (clk),
    .net_aresetn             (net_aresetn),
    .local_ip_address        (LOCAL_IP),
    .s_axis_rx_data_tdata    (s_data),
    .s_axis_rx_data_tkeep    (s_keep),
    .s_axis_rx_data_tlast    (s_last),
    .s_axis_rx_data_tvalid   (s_valid),
    .s_axis_rx_data_tready   (s_ready),
    .m_axis_udp_data_tdata   (m_data[0]),
    .m_axis_udp_data_tkeep   (m_keep[0]),
    .m_axis_udp_data_tlast   (m_last[0]),
    .m_axis_udp_data_tvalid  (m_valid[0]),
    .m_axis_udp_data_tready  (m_ready[0]),
    .m_axis_tcp_data_tdata   (m_data[1]),
    .m_axis_tcp_data_tkeep   (m_keep[1]),
    .m_axis_tcp_data_tlast   (m_last[1]),
    .m_axis_tcp_data_tvalid  (m_valid[1]),
    .m_axis_tcp_data_tready  (m_ready[1]),
    .m_axis_icmp_data_tdata  (m_data[2]),
    .m_axis_icmp_data_tkeep  (m_keep[2]),
    .m_axis_icmp_data_tlast  (m_last[2]),
    .m_axis_icmp_data_tvalid (m_valid[2]),
`ifdef IP_RX_DISPATCH_STATS_EN
    .drop_count              (drop_count),
    .runt_count              (runt_count),
`endif
    .m_axis_icmp_data_tready (m_ready[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Output ready driver: 0 = all ready, 1 = random, 2 = all stalled.
  initial begin
    m_ready = 3'b111;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 3'b111;
        1:       m_ready = 3'($urandom_range(0, 7));
        default: m_ready = 3'b000;
      endcase
    end
  end

  // Monitor: every output handshake must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (net_aresetn) begin
        for (int p = 0; p < 3; p++) begin
          if (m_valid[p] && m_ready[p]) begin
            checks++;
            rcv[p]++;
            if (exp_q.size() == 0) begin
              $display("FAIL unexpected_beat: port %0d data %h, required no beat", p, m_data[p]);
            end else begin
              exp_t e;
              e = exp_q.pop_front();
              if (e.port == p && m_data[p] === e.data && m_keep[p] === e.keep &&
                  m_last[p] === e.last) begin
                passed++;
              end else begin
                $display("FAIL beat: got port %0d data %h keep %h last %0b, required port %0d data %h keep %h last %0b",
                         p, m_data[p], m_keep[p], m_last[p], e.port, e.data, e.keep, e.last);
              end
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  function automatic logic [7:0] pkt_byte(input int id, input int n, input logic [3:0] ver,
                                          input logic [7:0] proto, input logic [31:0] dst);
    if (n == 0) return {ver, 4'h5};
    if (n == 9) return proto;
    if (n >= 16 && n <= 19) return dst[8*(n-16) +: 8];
    return 8'(n * 7 + id * 29 + 3);
  endfunction

  task automatic send_beat(input logic [WIDTH-1:0] d, input logic [KW-1:0] k, input logic l,
                           output int waits);
    bit got;
    got     = 0;
    waits   = 0;
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    s_valid = 1'b1;
    while (!got && waits <= 200) begin
      @(negedge clk);
      if (s_ready) got = 1;
      else waits++;
    end
    if (!got) begin
      checks++;
      $display("FAIL send_timeout: s_ready stayed 0 for %0d cycles, required 1", waits);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // port < 0 means the packet must be dropped.
  task automatic send_pkt(input int id, input logic [3:0] ver, input logic [7:0] proto,
                          input logic [31:0] dst, input int nbeats, input int port,
                          input bit chk_lat);
    for (int b = 0; b < nbeats; b++) begin
      logic [WIDTH-1:0] d;
      logic [KW-1:0]    k;
      logic             l;
      int               w;
      for (int i = 0; i < KW; i++) d[8*i +: 8] = pkt_byte(id, b * KW + i, ver, proto, dst);
      l = (b == nbeats - 1);
      k = l ? 8'h0F : 8'hFF;
      if (port >= 0) exp_q.push_back('{port: port, data: d, keep: k, last: l});
      send_beat(d, k, l, w);
      if (chk_lat && b == 1) check("latency_before_decision", 64'(m_valid), 64'd0);
      if (chk_lat && b == 2) check("latency_first_valid", 64'(m_valid), 64'b001);
      if (port < 0 && b >= DEC) check("drop_s_ready", 64'(w), 64'd0);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int r0, r1, r2, w;
    net_aresetn = 1'b0;
    s_data  = '0;
    s_keep  = '0;
    s_last  = 1'b0;
    s_valid = 1'b0;
    #2;
    check("reset_s_ready", 64'(s_ready), 64'd0);
    check("reset_valids", 64'(m_valid), 64'd0);
    repeat (3) @(posedge clk);
    #2;
    net_aresetn = 1'b1;
    @(posedge clk);
    #1;
    check("s_ready_after_reset", 64'(s_ready), 64'd1);
`ifdef IP_RX_DISPATCH_STATS_EN
    check("reset_drop_count", 64'(drop_count), 64'd0);
`endif

    // UDP packet to this node, all outputs ready.
    rdy_mode = 0;
    r0 = rcv[0]; r1 = rcv[1]; r2 = rcv[2];
    send_pkt(1, 4'd4, 8'h11, LOCAL_IP, 6, 0, 1);
    wait_idle("udp_drain");
    check("udp_beats", 64'(rcv[0] - r0), 64'd6);
    check("udp_no_tcp_icmp", 64'(rcv[1] - r1 + rcv[2] - r2), 64'd0);

    // Back-to-back TCP then ICMP with random output ready.
    rdy_mode = 1;
    r1 = rcv[1]; r2 = rcv[2];
    send_pkt(2, 4'd4, 8'h06, LOCAL_IP, 5, 1, 0);
    send_pkt(3, 4'd4, 8'h01, LOCAL_IP, 4, 2, 0);
    wait_idle("tcp_icmp_drain");
    check("tcp_beats", 64'(rcv[1] - r1), 64'd5);
    check("icmp_beats", 64'(rcv[2] - r2), 64'd4);
    rdy_mode = 0;

    // Foreign destination: dropped.
    r0 = rcv[0] + rcv[1] + rcv[2];
    send_pkt(4, 4'd4, 8'h11, OTHER_IP, 4, -1, 0);
    wait_idle("foreign_idle");
    check("foreign_dropped", 64'(rcv[0] + rcv[1] + rcv[2] - r0), 64'd0);
`ifdef IP_RX_DISPATCH_STATS_EN
    check("drop_count_foreign", 64'(drop_count), 64'd1);
`endif

    // Runt followed by a valid UDP packet.
    send_pkt(5, 4'd4, 8'h11, LOCAL_IP, 2, -1, 0);
`ifdef IP_RX_DISPATCH_STATS_EN
    check("runt_count", 64'(runt_count), 64'd1);
    check("drop_count_runt", 64'(drop_count), 64'd2);
`endif
    r0 = rcv[0];
    send_pkt(6, 4'd4, 8'h11, LOCAL_IP, 5, 0, 0);
    wait_idle("after_runt_drain");
    check("after_runt_udp_beats", 64'(rcv[0] - r0), 64'd5);

    // IGMP to broadcast and IPv6 version: both dropped.
    r0 = rcv[0] + rcv[1] + rcv[2];
    send_pkt(7, 4'd4, 8'h02, BCAST_IP, 4, -1, 0);
    send_pkt(8, 4'd6, 8'h11, LOCAL_IP, 4, -1, 0);
    wait_idle("igmp_v6_idle");
    check("igmp_v6_dropped", 64'(rcv[0] + rcv[1] + rcv[2] - r0), 64'd0);
`ifdef IP_RX_DISPATCH_STATS_EN
    check("drop_count_igmp_v6", 64'(drop_count), 64'd4);
    check("runt_count_stable", 64'(runt_count), 64'd1);
`endif

    // Reset while forwarding with the FIFO full and outputs stalled.
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    for (int b = 0; b < DEC; b++) begin
      logic [WIDTH-1:0] d;
      for (int i = 0; i < KW; i++) d[8*i +: 8] = pkt_byte(9, b * KW + i, 4'd4, 8'h11, LOCAL_IP);
      send_beat(d, 8'hFF, 1'b0, w);
    end
    check("stalled_udp_valid", 64'(m_valid), 64'b001);
    s_data  = 64'hDEAD_BEEF_0000_0003;
    s_keep  = 8'hFF;
    s_last  = 1'b0;
    s_valid = 1'b1;
    @(negedge clk);
    check("full_s_ready", 64'(s_ready), 64'd0);
    #2;
    net_aresetn = 1'b0;
    #1;
    check("midreset_valids", 64'(m_valid), 64'd0);
    check("midreset_s_ready", 64'(s_ready), 64'd0);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    net_aresetn = 1'b1;
    rdy_mode = 0;
    @(posedge clk);
    #1;
`ifdef IP_RX_DISPATCH_STATS_EN
    check("midreset_drop_count", 64'(drop_count), 64'd0);
`endif
    r0 = rcv[0];
    send_pkt(10, 4'd4, 8'h11, LOCAL_IP, 6, 0, 1);
    wait_idle("post_reset_drain");
    check("post_reset_udp_beats", 64'(rcv[0] - r0), 64'd6);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
